// File: rtl/sdr_pkg.sv
// Shared state encoding and default widths for the two-master SDRAM command arbiter.
package sdr_pkg;

  localparam int unsigned SDR_ADDR_W  = 23;
  localparam int unsigned SDR_DATA_W  = 32;
  localparam int unsigned SDR_TIMEOUT = 255;
  localparam int unsigned SDR_CNT_W   = 8;

  typedef enum logic [1:0] {
    ARB     = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } arb_state_t;

endpackage

// File: rtl/sdr_rr_pick.sv
// Two-way grant pick: fixed priority (m0 first) or round-robin against last_grant.
module sdr_rr_pick #(
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       grant_idx
);

  always_comb begin
    grant_idx = 1'b0;
    if (valid == 2'b11) begin
      grant_idx = (PRIO_MODE != 0) ? 1'b0 : ~last_grant;
    end else if (valid[1]) begin
      grant_idx = 1'b1;
    end
    grant = (valid == 2'b00) ? 2'b00 : (grant_idx ? 2'b10 : 2'b01);
  end

endmodule

// File: rtl/sdr_arbiter.sv
// Two-master arbiter in front of the SDRAM controller user port; one command in flight,
// read data routed back to the master that issued the read.
module sdr_arbiter
  import sdr_pkg::*;
#(
  parameter int unsigned ADDR_W    = SDR_ADDR_W,
  parameter int unsigned DATA_W    = SDR_DATA_W,
  parameter int unsigned TIMEOUT   = SDR_TIMEOUT,
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_valid,
  output logic              m0_ready,
  input  logic              m0_rw,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_valid,
  output logic              m1_ready,
  input  logic              m1_rw,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] sdr_addr,
  output logic              sdr_rw,
  output logic [DATA_W-1:0] sdr_wdata,
  output logic              sdr_in_valid,
  input  logic              sdr_busy,
  input  logic [DATA_W-1:0] sdr_rdata,
  input  logic              sdr_out_valid,
  output logic              timeout_err,
  input  logic              err_clr
);

  localparam int unsigned CNT_W = SDR_CNT_W;

  arb_state_t        state, state_d;
  logic [1:0]        req_valid;
  logic [1:0]        grant;
  logic              grant_idx;
  logic              last_grant;
  logic              owner;
  logic [CNT_W-1:0]  wait_cnt;
  logic              take;
  logic              rd_done;
  logic              rd_timeout;
  logic              stray;
  logic              sel_rw;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign req_valid = {m1_valid, m0_valid};

  sdr_rr_pick #(
    .PRIO_MODE (PRIO_MODE)
  ) u_pick (
    .valid      (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  // Winner's command fields
  always_comb begin
    sel_rw    = m0_rw;
    sel_addr  = m0_addr;
    sel_wdata = m0_wdata;
    if (grant_idx) begin
      sel_rw    = m1_rw;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB;
    end else begin
      state <= state_d;
    end
  end

  // Next state and accept; ISSUE follows the recorded rw held in sdr_rw
  always_comb begin
    state_d    = state;
    take       = 1'b0;
    rd_done    = 1'b0;
    rd_timeout = 1'b0;
    m0_ready   = 1'b0;
    m1_ready   = 1'b0;
    case (state)
      ARB: begin
        if (!sdr_busy && (grant != 2'b00)) begin
          take     = 1'b1;
          m0_ready = grant[0];
          m1_ready = grant[1];
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        state_d = sdr_rw ? ARB : WAIT_RD;
      end
      WAIT_RD: begin
        if (sdr_out_valid) begin
          rd_done = 1'b1;
          state_d = ARB;
        end else if (wait_cnt == CNT_W'(TIMEOUT)) begin
          rd_timeout = 1'b1;
          state_d    = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  assign stray = sdr_out_valid && (state != WAIT_RD);

  always_ff @(posedge clk) begin
    if (rst) begin
      sdr_addr     <= '0;
      sdr_rw       <= 1'b0;
      sdr_wdata    <= '0;
      sdr_in_valid <= 1'b0;
      m0_rvalid    <= 1'b0;
      m1_rvalid    <= 1'b0;
      m0_rdata     <= '0;
      m1_rdata     <= '0;
      timeout_err  <= 1'b0;
      last_grant   <= 1'b1;
      owner        <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      sdr_in_valid <= take;
      m0_rvalid    <= 1'b0;
      m1_rvalid    <= 1'b0;
      wait_cnt     <= (state == WAIT_RD) ? wait_cnt + CNT_W'(1) : '0;
      if (take) begin
        sdr_addr   <= sel_addr;
        sdr_rw     <= sel_rw;
        sdr_wdata  <= sel_wdata;
        owner      <= grant_idx;
        last_grant <= grant_idx;
      end
      // A timed-out read still completes towards its owner, with zero data
      if (rd_done || rd_timeout) begin
        if (owner) begin
          m1_rvalid <= 1'b1;
          m1_rdata  <= rd_done ? sdr_rdata : '0;
        end else begin
          m0_rvalid <= 1'b1;
          m0_rdata  <= rd_done ? sdr_rdata : '0;
        end
      end
      if (err_clr) begin
        timeout_err <= 1'b0;
      end else if (rd_timeout || stray) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdr_arbiter.sv
// Bench for sdr_arbiter: directed vector table, hand sequences and random traffic checked
// cycle by cycle against a timing-rule reference model; covers both arbitration modes.
module tb_sdr_arbiter;

  localparam int unsigned AW = 23;
  localparam int unsigned DW = 32;
  localparam int          TO = 255;

  typedef struct {
    bit            rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            lat;    // controller answers lat cycles after sdr_in_valid; 0 = never
    logic [DW-1:0] rdata;
  } req_t;

  typedef struct {
    bit            m;
    req_t          r;
    int            busy_pre;
    int            exp_rdy;
    int            exp_rv;
    logic [DW-1:0] exp_rd;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, err_clr;
  logic          m0_valid, m0_rw, m1_valid, m1_rw;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          sdr_busy, sdr_out_valid;
  logic [DW-1:0] sdr_rdata;

  logic          a_m0_ready, a_m0_rvalid, a_m1_ready, a_m1_rvalid, a_sdr_rw, a_sdr_in_valid, a_err;
  logic [DW-1:0] a_m0_rdata, a_m1_rdata, a_sdr_wdata;
  logic [AW-1:0] a_sdr_addr;
  logic          b_m0_ready, b_m0_rvalid, b_m1_ready, b_m1_rvalid, b_sdr_rw, b_sdr_in_valid, b_err;
  logic [DW-1:0] b_m0_rdata, b_m1_rdata, b_sdr_wdata;
  logic [AW-1:0] b_sdr_addr;

  sdr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .PRIO_MODE(0)) u_rr (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_ready(a_m0_ready), .m0_rw(m0_rw), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata),
    .m1_valid(m1_valid), .m1_ready(a_m1_ready), .m1_rw(m1_rw), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata),
    .sdr_addr(a_sdr_addr), .sdr_rw(a_sdr_rw), .sdr_wdata(a_sdr_wdata),
    .sdr_in_valid(a_sdr_in_valid), .sdr_busy(sdr_busy), .sdr_rdata(sdr_rdata),
    .sdr_out_valid(sdr_out_valid), .timeout_err(a_err), .err_clr(err_clr)
  );

  sdr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .PRIO_MODE(1)) u_fix (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_ready(b_m0_ready), .m0_rw(m0_rw), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
    .m1_valid(m1_valid), .m1_ready(b_m1_ready), .m1_rw(m1_rw), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
    .sdr_addr(b_sdr_addr), .sdr_rw(b_sdr_rw), .sdr_wdata(b_sdr_wdata),
    .sdr_in_valid(b_sdr_in_valid), .sdr_busy(sdr_busy), .sdr_rdata(sdr_rdata),
    .sdr_out_valid(sdr_out_valid), .timeout_err(b_err), .err_clr(err_clr)
  );

  // The instance under check: 0 = round-robin, 1 = fixed priority
  bit prio_sel;
  wire          d_m0_ready  = prio_sel ? b_m0_ready : a_m0_ready;
  wire          d_m1_ready  = prio_sel ? b_m1_ready : a_m1_ready;
  wire          d_m0_rvalid = prio_sel ? b_m0_rvalid : a_m0_rvalid;
  wire          d_m1_rvalid = prio_sel ? b_m1_rvalid : a_m1_rvalid;
  wire [DW-1:0] d_m0_rdata  = prio_sel ? b_m0_rdata : a_m0_rdata;
  wire [DW-1:0] d_m1_rdata  = prio_sel ? b_m1_rdata : a_m1_rdata;
  wire [AW-1:0] d_sdr_addr  = prio_sel ? b_sdr_addr : a_sdr_addr;
  wire          d_sdr_rw    = prio_sel ? b_sdr_rw : a_sdr_rw;
  wire [DW-1:0] d_sdr_wdata = prio_sel ? b_sdr_wdata : a_sdr_wdata;
  wire          d_in_valid  = prio_sel ? b_sdr_in_valid : a_sdr_in_valid;
  wire          d_err       = prio_sel ? b_err : a_err;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // stimulus knobs
  req_t        q0[$], q1[$];
  int          busy_hold;
  bit          rand_busy, stray_now, clr_now;
  int unsigned stray_pct, clr_pct;

  // reference model
  int            free_at, cmd_at, rd_start, resp_at, rv_at;
  bit            last_g, cmd_pend, rd_pend, rd_owner, rv_pend, rv_owner, err_m;
  req_t          cmd;
  logic [DW-1:0] resp_data, rv_data;
  logic [DW-1:0] mrd[2];

  // observations of the DUT
  int            obs_rdy_cyc, obs_rv_cyc;
  bit            obs_rv_who;
  logic [DW-1:0] obs_rv_data;
  bit            obs_grants[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
  endtask

  function automatic req_t mk(input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                              input int lat, input logic [DW-1:0] rd);
    req_t r;
    r.rw = rw; r.addr = a; r.wdata = wd; r.lat = lat; r.rdata = rd;
    return r;
  endfunction

  function automatic req_t rnd_req();
    return mk(($urandom_range(0, 1) == 1), AW'($urandom), DW'($urandom),
              int'($urandom_range(1, 10)), DW'($urandom));
  endfunction

  task automatic model_reset();
    free_at = 0; last_g = 1'b1; cmd_pend = 0; rd_pend = 0; rv_pend = 0; err_m = 0;
    mrd[0] = '0; mrd[1] = '0;
    obs_grants.delete();
  endtask

  // One clock: drive inputs after the edge, check at the falling edge, advance the model
  task automatic step();
    req_t h;
    bit   in_win, ov, can, win, set_err;
    @(posedge clk); #1;
    cyc++;
    m0_valid = (q0.size() > 0);
    if (m0_valid) begin h = q0[0]; m0_rw = h.rw; m0_addr = h.addr; m0_wdata = h.wdata; end
    m1_valid = (q1.size() > 0);
    if (m1_valid) begin h = q1[0]; m1_rw = h.rw; m1_addr = h.addr; m1_wdata = h.wdata; end
    sdr_busy = (busy_hold > 0) || (rand_busy && ($urandom_range(0, 3) == 0));
    if (busy_hold > 0) busy_hold--;
    in_win = rd_pend && (cyc >= rd_start);
    ov = in_win ? (cyc == resp_at) : (stray_now || ($urandom_range(0, 99) < stray_pct));
    sdr_out_valid = ov;
    sdr_rdata = (in_win && ov) ? resp_data : DW'($urandom);
    err_clr = clr_now || ($urandom_range(0, 99) < clr_pct);
    stray_now = 0;
    clr_now   = 0;

    @(negedge clk);
    check("sdr_in_valid", 64'(d_in_valid), 64'(cmd_pend && cyc == cmd_at));
    if (cmd_pend && cyc == cmd_at) begin
      check("sdr_addr", 64'(d_sdr_addr), 64'(cmd.addr));
      check("sdr_rw", 64'(d_sdr_rw), 64'(cmd.rw));
      if (cmd.rw) check("sdr_wdata", 64'(d_sdr_wdata), 64'(cmd.wdata));
      cmd_pend = 0;
    end
    if (rv_pend && cyc == rv_at) mrd[rv_owner] = rv_data;
    check("m0_rvalid", 64'(d_m0_rvalid), 64'(rv_pend && cyc == rv_at && !rv_owner));
    check("m1_rvalid", 64'(d_m1_rvalid), 64'(rv_pend && cyc == rv_at && rv_owner));
    if (rv_pend && cyc == rv_at) rv_pend = 0;
    check("m0_rdata", 64'(d_m0_rdata), 64'(mrd[0]));
    check("m1_rdata", 64'(d_m1_rdata), 64'(mrd[1]));
    check("timeout_err", 64'(d_err), 64'(err_m));
    if (d_m0_rvalid || d_m1_rvalid) begin
      obs_rv_cyc  = cyc;
      obs_rv_who  = d_m1_rvalid;
      obs_rv_data = d_m1_rvalid ? d_m1_rdata : d_m0_rdata;
    end

    can = (cyc >= free_at) && !sdr_busy && (m0_valid || m1_valid);
    if (m0_valid && m1_valid) win = prio_sel ? 1'b0 : !last_g;
    else win = m1_valid;
    check("m0_ready", 64'(d_m0_ready), 64'(can && !win));
    check("m1_ready", 64'(d_m1_ready), 64'(can && win));
    if (d_m0_ready || d_m1_ready) begin
      obs_rdy_cyc = cyc;
      obs_grants.push_back(d_m1_ready);
    end

    if (can) begin
      h = win ? q1.pop_front() : q0.pop_front();
      last_g = win; cmd = h; cmd_pend = 1; cmd_at = cyc + 1;
      if (h.rw) free_at = cyc + 2;
      else begin
        rd_pend = 1; rd_owner = win; rd_start = cyc + 2;
        resp_at = (h.lat == 0) ? -1 : cyc + 1 + h.lat;
        resp_data = h.rdata;
        free_at = 1 << 30;
      end
    end
    set_err = 0;
    if (in_win) begin
      if (ov) begin
        rv_pend = 1; rv_at = cyc + 1; rv_owner = rd_owner; rv_data = sdr_rdata;
        rd_pend = 0; free_at = cyc + 1;
      end else if (cyc == rd_start + TO) begin
        rv_pend = 1; rv_at = cyc + 1; rv_owner = rd_owner; rv_data = '0;
        rd_pend = 0; free_at = cyc + 1; set_err = 1;
      end
    end else if (ov) set_err = 1;
    if (err_clr) err_m = 0;
    else if (set_err) err_m = 1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    cyc++;
    rst = 1'b1; m0_valid = 0; m1_valid = 0; sdr_busy = 0; sdr_out_valid = 0; err_clr = 0;
    q0.delete(); q1.delete();
    @(posedge clk); #1;
    cyc++;
    rst = 1'b0;
    check("rst_flags", 64'({d_m0_ready, d_m1_ready, d_m0_rvalid, d_m1_rvalid, d_in_valid, d_err, d_sdr_rw}), 64'(0));
    check("rst_m0_rdata", 64'(d_m0_rdata), 64'(0));
    check("rst_m1_rdata", 64'(d_m1_rdata), 64'(0));
    check("rst_sdr_addr", 64'(d_sdr_addr), 64'(0));
    check("rst_sdr_wdata", 64'(d_sdr_wdata), 64'(0));
    model_reset();
  endtask

  task automatic run_idle(input int max_cyc);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || rd_pend || rv_pend || cmd_pend || cyc < free_at)
           && n < max_cyc) begin
      step();
      n++;
    end
    check("idle_reached", 64'(n < max_cyc), 64'(1));
  endtask

  task automatic contention(input bit mode);
    bit exp_g;
    prio_sel = mode;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(1'b0, AW'(32'h100 + i), '0, i + 1, DW'(32'hA0000000 + i)));
      q1.push_back(mk(1'b0, AW'(32'h200 + i), '0, 4 - i, DW'(32'hB0000000 + i)));
    end
    run_idle(300);
    check($sformatf("cont%0d_count", mode), 64'(obs_grants.size()), 64'(8));
    for (int i = 0; i < 8; i++) begin
      exp_g = mode ? (i >= 4) : (i % 2 == 1);
      if (i < obs_grants.size())
        check($sformatf("cont%0d_grant%0d", mode, i), 64'(obs_grants[i]), 64'(exp_g));
    end
  endtask

  task automatic random_phase(input bit mode, input int ncyc);
    prio_sel = mode;
    do_reset();
    rand_busy = 1; stray_pct = 2; clr_pct = 3;
    for (int i = 0; i < ncyc; i++) begin
      if (q0.size() < 3 && $urandom_range(0, 2) == 0) q0.push_back(rnd_req());
      if (q1.size() < 3 && $urandom_range(0, 2) == 0) q1.push_back(rnd_req());
      step();
    end
    rand_busy = 0; stray_pct = 0; clr_pct = 0;
    run_idle(400);
  endtask

  vec_t vecs[7];
  int   t0, rel;

  initial begin
    rst = 1'b1; err_clr = 0; m0_valid = 0; m1_valid = 0; m0_rw = 0; m1_rw = 0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    sdr_busy = 0; sdr_out_valid = 0; sdr_rdata = '0;
    busy_hold = 0; rand_busy = 0; stray_now = 0; clr_now = 0; stray_pct = 0; clr_pct = 0;
    prio_sel = 0;
    model_reset();

    vecs[0] = '{m: 0, r: mk(1, 23'h000123, 32'hCAFE0001, 0, '0), busy_pre: 0, exp_rdy: 0, exp_rv: -1, exp_rd: '0};
    vecs[1] = '{m: 1, r: mk(0, 23'h000040, '0, 6, 32'h12345678), busy_pre: 0, exp_rdy: 0, exp_rv: 8, exp_rd: 32'h12345678};
    vecs[2] = '{m: 0, r: mk(0, 23'h000777, '0, 1, 32'hDEADBEEF), busy_pre: 0, exp_rdy: 0, exp_rv: 3, exp_rd: 32'hDEADBEEF};
    vecs[3] = '{m: 1, r: mk(0, 23'h001000, '0, 1, 32'h0BADF00D), busy_pre: 0, exp_rdy: 0, exp_rv: 3, exp_rd: 32'h0BADF00D};
    vecs[4] = '{m: 0, r: mk(1, 23'h000200, 32'h00C0FFEE, 0, '0), busy_pre: 20, exp_rdy: 20, exp_rv: -1, exp_rd: '0};
    vecs[5] = '{m: 1, r: mk(0, 23'h0ABCDE, '0, 3, 32'h55AA55AA), busy_pre: 5, exp_rdy: 5, exp_rv: 10, exp_rd: 32'h55AA55AA};
    vecs[6] = '{m: 0, r: mk(0, 23'h7FFFFF, '0, 2, 32'hFFFFFFFF), busy_pre: 0, exp_rdy: 0, exp_rv: 4, exp_rd: 32'hFFFFFFFF};

    do_reset();
    for (int i = 0; i < 7; i++) begin
      t0 = cyc + 1; obs_rdy_cyc = -1; obs_rv_cyc = -1;
      busy_hold = vecs[i].busy_pre;
      if (vecs[i].m) q1.push_back(vecs[i].r);
      else q0.push_back(vecs[i].r);
      run_idle(400);
      check($sformatf("vec%0d_ready_at", i), 64'(obs_rdy_cyc - t0), 64'(vecs[i].exp_rdy));
      rel = (obs_rv_cyc < 0) ? -1 : obs_rv_cyc - t0;
      check($sformatf("vec%0d_rvalid_at", i), 64'(rel), 64'(vecs[i].exp_rv));
      if (vecs[i].exp_rv >= 0) begin
        check($sformatf("vec%0d_owner", i), 64'(obs_rv_who), 64'(vecs[i].m));
        check($sformatf("vec%0d_rdata", i), 64'(obs_rv_data), 64'(vecs[i].exp_rd));
      end
    end

    contention(1'b0);
    contention(1'b1);

    // Unanswered read: zero data to the owner after TIMEOUT wait cycles, sticky error
    prio_sel = 0;
    do_reset();
    t0 = cyc + 1; obs_rv_cyc = -1;
    q1.push_back(mk(0, 23'h000555, '0, 0, '0));
    run_idle(400);
    check("to_rvalid_at", 64'(obs_rv_cyc - t0), 64'(TO + 3));
    check("to_owner", 64'(obs_rv_who), 64'(1));
    check("to_rdata", 64'(obs_rv_data), 64'(0));
    check("to_err_set", 64'(d_err), 64'(1));
    clr_now = 1; step(); step();
    check("to_err_clr", 64'(d_err), 64'(0));

    // Stray response sets the error; a clear in the same cycle wins
    stray_now = 1; step(); step();
    check("stray_err", 64'(d_err), 64'(1));
    stray_now = 1; clr_now = 1; step(); step();
    check("clr_beats_set", 64'(d_err), 64'(0));

    // Reset while a read is outstanding discards it
    q0.push_back(mk(0, 23'h000666, '0, 0, '0));
    repeat (10) step();
    do_reset();
    repeat (20) step();

    random_phase(1'b0, 700);
    random_phase(1'b1, 700);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sdr_arbiter.md
Name: sdr_arbiter

Overview:
Two-requester arbiter in front of the SDRAM controller's single-command user port (addr/rw/data_in/in_valid/busy/out_valid). It accepts requests from two masters, such as the instruction-fetch path and the data/DMA path, and grants them round-robin or by fixed priority. It issues exactly one command at a time to the controller and routes read data back to the master that issued the read. It never overlaps a read with another command, so every controller out_valid is attributed to exactly one read.

Parameters:
ADDR_W, 23, user address width (matches controller user_addr)
DATA_W, 32, data width
TIMEOUT, 255, maximum cycles in WAIT_RD before the read is abandoned (8-bit counter)
PRIO_MODE, 0, 0 = round-robin; 1 = fixed priority, m0 always wins

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
m0_valid  in  1  m0 request pending; held high until m0_ready
m0_ready  out  1  one-cycle accept pulse for m0 (combinational from state and inputs)
m0_rw  in  1  1 = write, 0 = read
m0_addr  in  ADDR_W  m0 address
m0_wdata  in  DATA_W  m0 write data
m0_rvalid  out  1  one-cycle read-data-valid pulse to m0
m0_rdata  out  DATA_W  read data to m0
m1_*  same seven signals as m0_*, for requester 1
sdr_addr  out  ADDR_W  to controller user_addr
sdr_rw  out  1  to controller rw
sdr_wdata  out  DATA_W  to controller data_in
sdr_in_valid  out  1  one-cycle command pulse to controller
sdr_busy  in  1  controller busy
sdr_rdata  in  DATA_W  controller data_out
sdr_out_valid  in  1  controller read-data pulse
timeout_err  out  1  sticky error flag
err_clr  in  1  clears timeout_err

Behaviour:
- Reset: state ARB; all outputs 0; last_grant = 1, so m0 wins the first contention; any pending read is discarded.
- Outputs sdr_*, mX_rvalid and mX_rdata are registered. mX_ready is combinational.
- States and transitions:
  - ARB: when !sdr_busy and (m0_valid | m1_valid):
    - Select the winner.
    - Pulse winner_ready in this cycle (N).
    - Register addr/rw/wdata into sdr_* with sdr_in_valid = 1; these appear at N+1.
    - Record owner and rw; set last_grant = owner; go to ISSUE.
    - If sdr_busy, or no request is pending, stay in ARB and assert no ready.
  - ISSUE (N+1): sdr_in_valid is high for this cycle only. sdr_busy is ignored, because the controller raises busy one cycle after accepting a command. Next state is WAIT_RD if the command is a read, otherwise ARB.
  - WAIT_RD: sdr_in_valid = 0; an 8-bit counter counts up from 0.
    - On sdr_out_valid: capture sdr_rdata into owner_rdata and pulse owner_rvalid at the next cycle; go to ARB.
    - The earliest legal sdr_out_valid is the first WAIT_RD cycle (N+2). This is the cache-hit case and must be caught.
    - On counter == TIMEOUT with no out_valid: pulse owner_rvalid with rdata = 0, set timeout_err, go to ARB.
- Writes are complete, from the master's view, at the mX_ready pulse; no rvalid is produced for a write.
- Arbitration:
  - PRIO_MODE = 0: a single requester wins immediately. When both request, the winner is the one not equal to last_grant.
  - PRIO_MODE = 1: m0 wins whenever m0_valid is high.
- Back-to-back throughput: at most one command every 2 cycles, further limited by sdr_busy.
- Boundary cases:
  - sdr_out_valid outside WAIT_RD (a stray pulse, or a late pulse after timeout) is dropped and sets timeout_err.
  - err_clr has priority over a set event in the same cycle.
  - A master deasserting valid before ready is a protocol violation; the arbiter does not guard against it.
  - The arbiter never pulses both mX_ready outputs in the same cycle.
  - Both mX_rvalid are never high in the same cycle.
  - rdata of the non-owner holds its previous value.
- Controller refresh appears only as extended sdr_busy or a longer read latency; the arbiter needs no knowledge of refresh.

Decomposition:
- Shared package sdr_pkg holds:
  - state encoding: ARB = 2'd0, ISSUE = 2'd1, WAIT_RD = 2'd2
  - command/response field widths ADDR_W and DATA_W
  - the TIMEOUT default
- One sub-module, sdr_rr_pick: a 2-way grant pick from valid[1:0], last_grant and PRIO_MODE, outputting grant and grant_idx. It is combinational and reusable when the requester count grows.

Test Plan:
1. Single write: m0 write addr 23'h000123, data 32'hCAFE0001, controller idle. Required: m0_ready pulses at N; sdr_in_valid=1 with sdr_addr=23'h000123 and sdr_rw=1 at N+1 only; no m0_rvalid.
2. Read with latency: m1 read addr 23'h000040; model asserts sdr_out_valid 6 cycles after sdr_in_valid with data 32'h12345678. Required: m1_rvalid=1 and m1_rdata=32'h12345678 one cycle later; m0_rvalid stays 0.
3. Contention, round-robin: m0 and m1 both hold valid reads, with 4 reads each queued. Required: grant order m0, m1, m0, m1, ... and no second sdr_in_valid before the prior out_valid. With PRIO_MODE=1, all m0 reads complete first.
4. Cache-hit latency: model returns sdr_out_valid at N+2, the first WAIT_RD cycle. Required: data is captured and routed to the correct owner.
5. Busy hold-off: sdr_busy is high for 20 cycles (refresh) while m0_valid=1. Required: no m0_ready and no sdr_in_valid until the first cycle with sdr_busy=0; then normal issue.
6. Timeout and reset: model never responds to a read with TIMEOUT=255. Required: owner rvalid with rdata=0 and timeout_err=1 at count 255; err_clr clears it. Asserting rst during WAIT_RD returns the block to ARB with all outputs 0.
